// File: rtl/vchk_pkg.sv
// Shared encodings, the queue-entry control tag and the per-lane expected-result
// function used by the vector result checker.
package vchk_pkg;

  typedef enum logic [1:0] {
    OP_VADD = 2'd0,
    OP_VMUL = 2'd1
  } vchk_op_e;

  typedef enum logic [2:0] {
    SEW_8  = 3'd0,
    SEW_16 = 3'd1,
    SEW_32 = 3'd2,
    SEW_64 = 3'd3
  } vchk_sew_e;

  localparam int unsigned LANE_W = 64;
  localparam int unsigned CTL_W  = 5;

  // Low bits of every queue entry; vs1/vs2 sit above it as {vs1, vs2, ctl}.
  typedef struct packed {
    logic [1:0] op;
    logic [2:0] vsew;
  } vchk_ctl_t;

  // Expected 64-bit lane for one element width; each element wraps on its own,
  // so nothing ever crosses an element boundary.
  function automatic logic [63:0] lane_expect(input logic [63:0] a,
                                              input logic [63:0] b,
                                              input logic        is_mul,
                                              input logic [1:0]  sew);
    logic [63:0] r;
    r = '0;
    case (sew)
      2'd0: for (int i = 0; i < 8; i++)
              r[8*i +: 8] = is_mul ? a[8*i +: 8] * b[8*i +: 8] : a[8*i +: 8] + b[8*i +: 8];
      2'd1: for (int i = 0; i < 4; i++)
              r[16*i +: 16] = is_mul ? a[16*i +: 16] * b[16*i +: 16] : a[16*i +: 16] + b[16*i +: 16];
      2'd2: for (int i = 0; i < 2; i++)
              r[32*i +: 32] = is_mul ? a[32*i +: 32] * b[32*i +: 32] : a[32*i +: 32] + b[32*i +: 32];
      default: r = is_mul ? a * b : a + b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/vresult_checker_if.sv
// Operand and result buses of the vector result checker.
interface vresult_checker_if #(
  parameter int unsigned DATA_W = 128
);
  // Operand handshake: a set transfers on a rising edge where op_valid_i and
  // op_ready_o are both high; the master holds vs1/vs2/op/vsew stable while
  // op_valid_i is high. The result side has no ready: res_valid_i is consumed
  // in the cycle it is presented.
  logic              op_valid_i;
  logic              op_ready_o;
  logic [DATA_W-1:0] vs1_i;
  logic [DATA_W-1:0] vs2_i;
  logic [1:0]        op_i;
  logic [2:0]        vsew_i;
  logic              res_valid_i;
  logic [DATA_W-1:0] res_i;

  modport master (
    output op_valid_i, vs1_i, vs2_i, op_i, vsew_i, res_valid_i, res_i,
    input  op_ready_o
  );

  modport slave (
    input  op_valid_i, vs1_i, vs2_i, op_i, vsew_i, res_valid_i, res_i,
    output op_ready_o
  );
endinterface

// File: rtl/vresult_checker_fifo.sv
// Power-of-two synchronous FIFO with show-ahead read data; a pop frees the
// head slot in the same cycle, so a push is also taken when full and popping.
module vresult_checker_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full    = (cnt_q == (PTR_W+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_pop  = pop && !empty && !clr;
  assign do_push = push && (!full || do_pop) && !clr;
  assign rdata   = mem[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + (PTR_W+1)'(1);
        2'b01:   cnt_d = cnt_q - (PTR_W+1)'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/vresult_checker.sv
// Queues operand sets, recomputes vadd/vmul per element on each datapath
// result and reports a registered per-byte comparison one cycle after the pop.
module vresult_checker
  import vchk_pkg::*;
#(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear_i,
  vresult_checker_if.slave    bus,
  output logic                chk_valid_o,
  output logic                mismatch_o,
  output logic [DATA_W/8-1:0] byte_err_o,
  output logic [CNT_W-1:0]    chk_count_o,
  output logic [CNT_W-1:0]    err_count_o,
  output logic                full_o,
  output logic                empty_o,
  output logic                overflow_o,
  output logic                underflow_o,
  output logic                illegal_o
);
  localparam int unsigned NB      = DATA_W / 8;
  localparam int unsigned LANES   = DATA_W / LANE_W;
  localparam int unsigned ENTRY_W = 2 * DATA_W + CTL_W;

  logic               fifo_full, fifo_empty;
  logic [ENTRY_W-1:0] head;
  vchk_ctl_t          head_ctl;
  logic [DATA_W-1:0]  head_vs1, head_vs2, exp_res;
  logic [NB-1:0]      cmp_mask;
  logic               pop_fire, legal, is_mul;

  logic              chk_valid_q, chk_valid_d;
  logic [NB-1:0]     byte_err_q, byte_err_d;
  logic [CNT_W-1:0]  chk_cnt_q, chk_cnt_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic              ovf_q, ovf_d, unf_q, unf_d, ill_q, ill_d;

  vresult_checker_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (clear_i),
    .push  (bus.op_valid_i),
    .pop   (bus.res_valid_i),
    .wdata ({bus.vs1_i, bus.vs2_i, bus.op_i, bus.vsew_i}),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.op_ready_o = !fifo_full;
  assign head_ctl       = head[CTL_W-1:0];
  assign head_vs2       = head[CTL_W +: DATA_W];
  assign head_vs1       = head[CTL_W+DATA_W +: DATA_W];
  assign pop_fire       = bus.res_valid_i && !fifo_empty && !clear_i;
  assign legal          = !head_ctl.op[1] && !head_ctl.vsew[2];
  assign is_mul         = (head_ctl.op == OP_VMUL);

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [LANE_W-1:0] a, b, e;
    assign a = head_vs1[LANE_W*l +: LANE_W];
    assign b = head_vs2[LANE_W*l +: LANE_W];
    always_comb begin
      e = '0;
      case (head_ctl.vsew[1:0])
        2'd0:    e = lane_expect(a, b, is_mul, 2'd0);
        2'd1:    e = lane_expect(a, b, is_mul, 2'd1);
        2'd2:    e = lane_expect(a, b, is_mul, 2'd2);
        default: e = lane_expect(a, b, is_mul, 2'd3);
      endcase
    end
    assign exp_res[LANE_W*l +: LANE_W] = e;
  end

  always_comb begin
    cmp_mask = '0;
    for (int k = 0; k < NB; k++) cmp_mask[k] = (exp_res[8*k +: 8] != bus.res_i[8*k +: 8]);
  end

  // Counters advance on the same edge that raises chk_valid_o, so the new count
  // is visible alongside the pulse that caused it.
  always_comb begin
    chk_valid_d = 1'b0;
    byte_err_d  = byte_err_q;
    chk_cnt_d   = chk_cnt_q;
    err_cnt_d   = err_cnt_q;
    ovf_d       = ovf_q;
    unf_d       = unf_q;
    ill_d       = ill_q;
    if (clear_i) begin
      byte_err_d = '0;
      chk_cnt_d  = '0;
      err_cnt_d  = '0;
      ovf_d      = 1'b0;
      unf_d      = 1'b0;
      ill_d      = 1'b0;
    end else begin
      if (bus.op_valid_i && fifo_full && !pop_fire) ovf_d = 1'b1;
      if (bus.res_valid_i && fifo_empty)            unf_d = 1'b1;
      if (pop_fire && !legal)                       ill_d = 1'b1;
      if (pop_fire && legal) begin
        chk_valid_d = 1'b1;
        byte_err_d  = cmp_mask;
        if (!(&chk_cnt_q)) chk_cnt_d = chk_cnt_q + CNT_W'(1);
        if ((|cmp_mask) && !(&err_cnt_q)) err_cnt_d = err_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      chk_valid_q <= 1'b0;
      byte_err_q  <= '0;
      chk_cnt_q   <= '0;
      err_cnt_q   <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      ill_q       <= 1'b0;
    end else begin
      chk_valid_q <= chk_valid_d;
      byte_err_q  <= byte_err_d;
      chk_cnt_q   <= chk_cnt_d;
      err_cnt_q   <= err_cnt_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
      ill_q       <= ill_d;
    end
  end

  assign chk_valid_o = chk_valid_q;
  assign byte_err_o  = byte_err_q;
  assign mismatch_o  = |byte_err_q;
  assign chk_count_o = chk_cnt_q;
  assign err_count_o = err_cnt_q;
  assign full_o      = fifo_full;
  assign empty_o     = fifo_empty;
  assign overflow_o  = ovf_q;
  assign underflow_o = unf_q;
  assign illegal_o   = ill_q;

endmodule

// File: tb/tb_vresult_checker.sv
// Self-checking bench for vresult_checker: a reference queue model predicts
// every comparison and the status outputs after each cycle.
module tb_vresult_checker;
  localparam int DW = 128;
  localparam int NB = DW / 8;
  localparam int DEPTH = 8;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clear = 1'b0;
  logic chk_valid_o, mismatch_o, full_o, empty_o, overflow_o, underflow_o, illegal_o;
  logic [NB-1:0] byte_err_o;
  logic [CW-1:0] chk_count_o, err_count_o;

  vresult_checker_if #(.DATA_W(DW)) bus ();

  vresult_checker #(.DATA_W(DW), .DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .clear_i(clear), .bus(bus),
    .chk_valid_o(chk_valid_o), .mismatch_o(mismatch_o), .byte_err_o(byte_err_o),
    .chk_count_o(chk_count_o), .err_count_o(err_count_o),
    .full_o(full_o), .empty_o(empty_o),
    .overflow_o(overflow_o), .underflow_o(underflow_o), .illegal_o(illegal_o)
  );

  always #5 clk = ~clk;

  // scoreboard and reference model state
  logic [NB-1:0] exp_q[$];
  logic [NB-1:0] pend_q[$];
  logic [DW-1:0] ref_res_q[$];
  logic          ref_legal_q[$];
  int            m_chk, m_err;
  logic          m_ovf, m_unf, m_ill;
  logic [NB-1:0] m_mask;
  int            n_assert = 0;
  int            n_fail = 0;
  logic          mon_en = 1'b0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] ref_calc(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                             input logic [1:0] op, input logic [2:0] sew_code);
    int sew;
    logic [DW-1:0] m, ea, eb, er, r;
    sew = 8 << sew_code;
    m = (sew == 64) ? {{(DW-64){1'b0}}, {64{1'b1}}} : ((DW'(1) << sew) - DW'(1));
    r = '0;
    for (int e = 0; e < DW / sew; e++) begin
      ea = (a >> (e * sew)) & m;
      eb = (b >> (e * sew)) & m;
      er = (op == 2'd1) ? ea * eb : ea + eb;
      r  = r | ((er & m) << (e * sew));
    end
    return r;
  endfunction

  function automatic logic [NB-1:0] byte_diff(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [NB-1:0] d;
    for (int k = 0; k < NB; k++) d[k] = (a[8*k +: 8] != b[8*k +: 8]);
    return d;
  endfunction

  function automatic int sat_inc(input int v);
    return (v == (1 << CW) - 1) ? v : v + 1;
  endfunction

  // Applies the stimulus currently on the bus to the model for the coming edge.
  task automatic model_step();
    logic pop, push, lg;
    logic [DW-1:0] r;
    logic [NB-1:0] mk;
    if (!rst || clear) begin
      ref_res_q.delete(); ref_legal_q.delete(); pend_q.delete();
      m_chk = 0; m_err = 0; m_ovf = 0; m_unf = 0; m_ill = 0; m_mask = '0;
      return;
    end
    pop  = bus.res_valid_i && (ref_res_q.size() > 0);
    push = bus.op_valid_i && ((ref_res_q.size() < DEPTH) || pop);
    if (bus.res_valid_i && ref_res_q.size() == 0) m_unf = 1'b1;
    if (bus.op_valid_i && !push) m_ovf = 1'b1;
    if (pop) begin
      r  = ref_res_q.pop_front();
      lg = ref_legal_q.pop_front();
      if (lg) begin
        mk = byte_diff(r, bus.res_i);
        pend_q.push_back(mk);
        m_mask = mk;
        m_chk = sat_inc(m_chk);
        if (mk != '0) m_err = sat_inc(m_err);
      end else begin
        m_ill = 1'b1;
      end
    end
    if (push) begin
      lg = (bus.op_i < 2'd2) && (bus.vsew_i < 3'd4);
      ref_res_q.push_back(lg ? ref_calc(bus.vs1_i, bus.vs2_i, bus.op_i, bus.vsew_i) : '0);
      ref_legal_q.push_back(lg);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    while (pend_q.size() > 0) exp_q.push_back(pend_q.pop_front());
    bus.op_valid_i  = 1'b0;
    bus.res_valid_i = 1'b0;
    clear           = 1'b0;
  endtask

  task automatic set_push(input logic [DW-1:0] v1, input logic [DW-1:0] v2,
                          input logic [1:0] op, input logic [2:0] sew);
    bus.op_valid_i = 1'b1;
    bus.vs1_i = v1; bus.vs2_i = v2; bus.op_i = op; bus.vsew_i = sew;
  endtask

  task automatic set_res(input logic [DW-1:0] r);
    bus.res_valid_i = 1'b1;
    bus.res_i = r;
  endtask

  task automatic check_status();
    check("empty", empty_o, ref_res_q.size() == 0);
    check("full", full_o, ref_res_q.size() == DEPTH);
    check("op_ready", bus.op_ready_o, ref_res_q.size() != DEPTH);
    check("overflow", overflow_o, m_ovf);
    check("underflow", underflow_o, m_unf);
    check("illegal", illegal_o, m_ill);
    check("chk_count", chk_count_o, CW'(m_chk));
    check("err_count", err_count_o, CW'(m_err));
    check("byte_err_hold", byte_err_o, m_mask);
  endtask

  // Compares each registered comparison against the scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() > 0) begin
        logic [NB-1:0] em;
        em = exp_q.pop_front();
        check("chk_valid", chk_valid_o, 1'b1);
        check("byte_err", byte_err_o, em);
        check("mismatch", mismatch_o, |em);
      end else begin
        check("chk_idle", chk_valid_o, 1'b0);
      end
    end
  end

  initial begin
    logic [DW-1:0] ones_ff, ones_01, v32, r;
    int k;
    ones_ff = {NB{8'hFF}};
    ones_01 = {NB{8'h01}};
    v32     = {(DW/32){32'h0001_0000}};
    bus.op_valid_i = 0; bus.res_valid_i = 0;
    bus.vs1_i = '0; bus.vs2_i = '0; bus.op_i = '0; bus.vsew_i = '0; bus.res_i = '0;

    rst = 1'b0; tick(); tick();
    rst = 1'b1; mon_en = 1'b1;
    check_status();

    // 8-bit vadd wraps to zero
    set_push(ones_ff, ones_01, 2'd0, 3'd0); tick();
    set_res('0); tick();
    check("sew8_cnt", chk_count_o, 16'd1);
    check_status();

    // 16-bit vadd: 0xFFFF + 0x0101 = 0x0100 per element, no cross-element carry
    clear = 1'b1; tick();
    set_push(ones_ff, ones_01, 2'd0, 3'd1); tick();
    set_res({(DW/16){16'h0100}}); tick();
    check("sew16_cnt", chk_count_o, 16'd1);
    set_push(ones_ff, ones_01, 2'd0, 3'd1); tick();
    set_res('0); tick();
    check("sew16_mask", byte_err_o, 16'hAAAA);
    check_status();

    // 32-bit vmul: 0x10000 * 0x10000 wraps to zero; then byte 5 corrupted
    clear = 1'b1; tick();
    set_push(v32, v32, 2'd1, 3'd2); tick();
    set_res('0); tick();
    set_push(v32, v32, 2'd1, 3'd2); tick();
    r = '0; r[47:40] = 8'hFF;
    set_res(r); tick();
    check("mul_mask", byte_err_o, 16'h0020);
    check("mul_err", err_count_o, 16'd1);
    tick();
    check_status();

    // fill, overflow, push+pop at full, drain, underflow
    clear = 1'b1; tick();
    for (int i = 0; i < DEPTH; i++) begin
      set_push({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
               2'($urandom_range(0, 1)), 3'($urandom_range(0, 3)));
      tick();
    end
    check("ready_at_full", bus.op_ready_o, 1'b0);
    set_push(ones_ff, ones_01, 2'd0, 3'd0); tick();
    check("overflow_set", overflow_o, 1'b1);
    set_push(ones_ff, ones_01, 2'd1, 3'd3); set_res(ref_res_q[0]); tick();
    check("full_after_pushpop", full_o, 1'b1);
    check_status();
    for (int i = 0; i < DEPTH; i++) begin
      set_res(ref_res_q[0]); tick();
    end
    set_res('0); tick();
    check("underflow_set", underflow_o, 1'b1);
    tick();
    check_status();

    // push into an empty queue while a result arrives: no comparison
    clear = 1'b1; tick();
    set_push(ones_ff, ones_01, 2'd0, 3'd0); set_res('0); tick();
    check_status();
    // clear together with a pop
    set_push(ones_ff, ones_01, 2'd0, 3'd0); tick();
    set_res('0); clear = 1'b1; tick();
    check("clear_empty", empty_o, 1'b1);
    check("clear_cnt", chk_count_o, 16'd0);
    tick();
    check_status();

    // illegal vsew and illegal op
    set_push(ones_ff, ones_01, 2'd0, 3'd3); tick();
    set_res('0); tick();
    set_push(ones_ff, ones_01, 2'd0, 3'd5); tick();
    set_res('0); tick();
    check("illegal_vsew", illegal_o, 1'b1);
    check("illegal_cnt", chk_count_o, 16'd1);
    clear = 1'b1; tick();
    set_push(ones_ff, ones_01, 2'd2, 3'd0); tick();
    set_res('0); tick();
    check("illegal_op", illegal_o, 1'b1);
    check_status();

    // reset lands on the pop edge: the comparison is cancelled
    set_push(ones_ff, ones_01, 2'd0, 3'd0); tick();
    set_res('0); rst = 1'b0; tick();
    rst = 1'b1; tick();
    check_status();

    // randomised traffic
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 2) != 0)
        set_push({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
                 2'($urandom_range(0, 1)), 3'($urandom_range(0, 3)));
      if ($urandom_range(0, 2) == 0) begin
        r = (ref_res_q.size() > 0) ? ref_res_q[0] : '0;
        if ($urandom_range(0, 2) == 0) begin
          k = $urandom_range(0, NB - 1);
          r[8*k +: 8] = r[8*k +: 8] ^ 8'($urandom_range(1, 255));
        end
        set_res(r);
      end
      tick();
    end
    tick(); tick();
    check_status();
    check("scoreboard_drained", DW'(exp_q.size()), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
